// File: rtl/bitop_arbiter.sv
// Round-robin arbiter/sequencer sharing one XOR/AND unit between two requesters.
// Define BITOP_STATS_EN to add the saturating op_count result counter port.
module bitop_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req0_mode,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    input  logic         req1_mode,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [W-1:0] res_data,
    output logic         res_src,
    output logic         busy
`ifdef BITOP_STATS_EN
    ,
    output logic [15:0]  op_count
`endif
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    logic [1:0]   r_state;
    logic         r_last_grant;
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    logic         r_mode;
    logic         r_src;
    logic [W-1:0] r_res_data;
    logic         r_res_src;

    logic [1:0]   w_valid;
    logic [1:0]   w_ready;
    logic         w_idle;
    logic         w_grant;
    logic         w_accept;
    logic [W-1:0] w_sel_a;
    logic [W-1:0] w_sel_b;
    logic         w_sel_mode;

    assign w_valid = {req1_valid, req0_valid};
    assign w_idle  = (r_state == ST_IDLE);

    // Under contention the grant goes to whoever did not win last time.
    always_comb begin
        w_grant = 1'b0;
        case (w_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    // Ready is masked by rst so nothing looks accepted on a reset cycle.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ready
            assign w_ready[gi] = w_idle && !rst && w_valid[gi] && (w_grant == 1'(gi));
        end
    endgenerate

    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];
    assign w_accept   = |w_ready;

    assign w_sel_a    = w_grant ? req1_a    : req0_a;
    assign w_sel_b    = w_grant ? req1_b    : req0_b;
    assign w_sel_mode = w_grant ? req1_mode : req0_mode;

    assign res_valid = (r_state == ST_OUT);
    assign res_data  = r_res_data;
    assign res_src   = r_res_src;
    assign busy      = !w_idle;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
            r_a          <= '0;
            r_b          <= '0;
            r_mode       <= 1'b0;
            r_src        <= 1'b0;
            r_res_data   <= '0;
            r_res_src    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a          <= w_sel_a;
                        r_b          <= w_sel_b;
                        r_mode       <= w_sel_mode;
                        r_src        <= w_grant;
                        r_last_grant <= w_grant;
                        r_state      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_res_data <= r_mode ? (r_a & r_b) : (r_a ^ r_b);
                    r_res_src  <= r_src;
                    r_state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (res_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef BITOP_STATS_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_count <= '0;
        end else if (res_valid && res_ready && (r_op_count != 16'hFFFF)) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule

// File: tb/tb_bitop_arbiter.sv
// Bench for bitop_arbiter: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_bitop_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_a = 8'h00;
    logic [7:0] req0_b = 8'h00;
    logic       req0_mode = 1'b0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_a = 8'h00;
    logic [7:0] req1_b = 8'h00;
    logic       req1_mode = 1'b0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_data;
    logic       res_src;
    logic       busy;
`ifdef BITOP_STATS_EN
    logic [15:0] op_count;
`endif

    int checks = 0;
    int failures = 0;

    bitop_arbiter #(.W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_mode  (req0_mode),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_mode  (req1_mode),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src),
        .busy       (busy)
`ifdef BITOP_STATS_EN
        ,
        .op_count   (op_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out waiting for DUT", name);
    endtask

    // Inputs change only right after a rising edge; outputs are read at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    // An op is "in flight" from its accept edge until its result handshake;
    // its result is offered starting two edges after acceptance.
    bit          started = 0;
    bit          m_inflight = 0;
    int          m_age = 0;
    int          m_last = 1;
    logic [7:0]  q_data[$];
    logic        q_src[$];
    int          m_count = 0;
    int          hs_total = 0;

    always @(negedge clk) begin
        int  g;
        bit  idle, e0, e1, ev;
        if (rst) begin
            if (started) begin
                chk("rst_req0_ready", req0_ready, 0);
                chk("rst_req1_ready", req1_ready, 0);
            end
            started = 1;
            m_inflight = 0;
            m_age = 0;
            m_last = 1;
            q_data.delete();
            q_src.delete();
            m_count = 0;
        end else if (started) begin
            if (m_inflight && m_age < 2) m_age++;
            idle = !m_inflight;
            if (req0_valid && req1_valid) g = 1 - m_last;
            else g = req0_valid ? 0 : 1;
            e0 = idle && req0_valid && (g == 0);
            e1 = idle && req1_valid && (g == 1);
            ev = m_inflight && (m_age == 2);
            chk("model_req0_ready", req0_ready, e0);
            chk("model_req1_ready", req1_ready, e1);
            chk("model_res_valid", res_valid, ev);
            chk("model_busy", busy, m_inflight);
`ifdef BITOP_STATS_EN
            chk("model_op_count", op_count, m_count);
`endif
            if (ev) begin
                if (q_data.size() > 0) begin
                    chk("model_res_data", res_data, q_data[0]);
                    chk("model_res_src", res_src, q_src[0]);
                end else begin
                    failures++;
                    $display("FAIL model_result no expected op pending actual_data=%0h", res_data);
                end
                if (res_ready) begin
                    void'(q_data.pop_front());
                    void'(q_src.pop_front());
                    m_inflight = 0;
                    if (m_count < 16'hFFFF) m_count++;
                    hs_total++;
                end
            end
            if (e0) begin
                q_data.push_back(req0_mode ? (req0_a & req0_b) : (req0_a ^ req0_b));
                q_src.push_back(1'b0);
            end
            if (e1) begin
                q_data.push_back(req1_mode ? (req1_a & req1_b) : (req1_a ^ req1_b));
                q_src.push_back(1'b1);
            end
            if (e0 || e1) begin
                m_last = g;
                m_inflight = 1;
                m_age = 0;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic single_op(input int r, input logic [7:0] a, input logic [7:0] b,
                             input logic m, output logic [7:0] d, output logic s);
        bit acc, got;
        tick();
        res_ready = 1'b1;
        if (r == 0) begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_mode = m;
        end else begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_mode = m;
        end
        acc = 0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if ((r == 0) ? req0_ready : req1_ready) begin
                acc = 1;
                break;
            end
            tick();
        end
        if (!acc) timeout_fail("single_op_accept");
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        got = 0;
        d = 8'h00;
        s = 1'b0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (res_valid && res_ready) begin
                d = res_data;
                s = res_src;
                got = 1;
                break;
            end
            tick();
        end
        if (!got) timeout_fail("single_op_result");
    endtask

    task automatic drain(input int n);
        for (int k = 0; k < n; k++) begin
            tick();
            sample();
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] d, hd;
        logic       s, hsrc;
        logic       seq[$];
        bit         a0, a1, seen, flag1;
        int         n0, n1, h;

        tick();
        tick();
        rst = 1'b0;
        sample();
        chk("reset_res_valid", res_valid, 0);
        chk("reset_res_data", res_data, 0);
        chk("reset_res_src", res_src, 0);
        chk("reset_busy", busy, 0);
        chk("reset_req0_ready", req0_ready, 0);
        chk("reset_req1_ready", req1_ready, 0);
`ifdef BITOP_STATS_EN
        chk("reset_op_count", op_count, 0);
`endif

        // Single XOR with cycle-exact timing.
        tick();
        req0_valid = 1'b1; req0_a = 8'hA5; req0_b = 8'h0F; req0_mode = 1'b0; res_ready = 1'b1;
        sample();
        chk("xor_ready_c0", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        sample();
        chk("xor_busy_c1", busy, 1);
        chk("xor_valid_c1", res_valid, 0);
        tick();
        sample();
        chk("xor_valid_c2", res_valid, 1);
        chk("xor_data_c2", res_data, 8'hAA);
        chk("xor_src_c2", res_src, 0);
        tick();
        sample();
        chk("xor_busy_c3", busy, 0);

        // Single AND from requester 1.
        single_op(1, 8'hF0, 8'h3C, 1'b1, d, s);
        chk("and_data", d, 8'h30);
        chk("and_src", s, 1);

        // Contention: both valid continuously, four ops each.
        tick();
        req0_valid = 1'b1; req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 1'($urandom);
        req1_valid = 1'b1; req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 1'($urandom);
        res_ready = 1'b1;
        n0 = 0;
        n1 = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            sample();
            a0 = req0_ready;
            a1 = req1_ready;
            if (res_valid && res_ready) seq.push_back(res_src);
            if (seq.size() == 8) break;
            tick();
            if (a0) begin
                n0++;
                if (n0 < 4) begin
                    req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 1'($urandom);
                end else req0_valid = 1'b0;
            end
            if (a1) begin
                n1++;
                if (n1 < 4) begin
                    req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 1'($urandom);
                end else req1_valid = 1'b0;
            end
        end
        if (seq.size() != 8) timeout_fail("contention_results");
        for (int i = 0; i < seq.size(); i++) chk("contention_order", seq[i], 32'(i % 2));
        drain(2);

        // Backpressure: hold res_ready low for 10 cycles of OUT.
        tick();
        res_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 8'h3C; req0_b = 8'h55; req0_mode = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (req0_ready) begin seen = 1; break; end
            tick();
        end
        if (!seen) timeout_fail("bp_accept");
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_a = 8'hC3; req1_b = 8'h0F; req1_mode = 1'b1;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (res_valid) begin seen = 1; break; end
            tick();
        end
        if (!seen) timeout_fail("bp_valid");
        hd = res_data;
        hsrc = res_src;
        chk("bp_data_value", hd, 8'h69);
        for (int k = 0; k < 10; k++) begin
            chk("bp_valid_held", res_valid, 1);
            chk("bp_data_stable", res_data, hd);
            chk("bp_src_stable", res_src, hsrc);
            chk("bp_req0_ready_low", req0_ready, 0);
            chk("bp_req1_ready_low", req1_ready, 0);
            tick();
            sample();
        end
        tick();
        res_ready = 1'b1;
        h = 0;
        for (int k = 0; k < 3; k++) begin
            sample();
            if (res_valid && res_ready) h++;
            flag1 = req1_ready;
            tick();
            if (flag1) req1_valid = 1'b0;
        end
        chk("bp_one_handshake", h, 1);
        sample();
        drain(4);

        // Reset in EXEC aborts the op.
        tick();
        req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_mode = 1'b0;
        sample();
        chk("rstmid_accept", req0_ready, 1);
        tick();
        req0_valid = 1'b0;
        rst = 1'b1;
        sample();
        chk("rstmid_in_exec", busy, 1);
        tick();
        rst = 1'b0;
        sample();
        chk("rstmid_res_valid", res_valid, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_res_data", res_data, 0);
        chk("rstmid_res_src", res_src, 0);
        chk("rstmid_req0_ready", req0_ready, 0);
        chk("rstmid_req1_ready", req1_ready, 0);
        for (int k = 0; k < 3; k++) begin
            tick();
            sample();
            chk("rstmid_no_result", res_valid, 0);
        end
        tick();
        req0_valid = 1'b1; req0_a = 8'hFF; req0_b = 8'h81; req0_mode = 1'b1;
        req1_valid = 1'b1; req1_a = 8'h0A; req1_b = 8'h05; req1_mode = 1'b0;
        sample();
        chk("rstmid_first_grant0", req0_ready, 1);
        chk("rstmid_first_grant1", req1_ready, 0);
        tick();
        req0_valid = 1'b0;
        seen = 0;
        for (int n = 0; n < 20; n++) begin
            sample();
            if (req1_ready) begin seen = 1; break; end
            tick();
        end
        if (!seen) timeout_fail("rstmid_req1_accept");
        tick();
        req1_valid = 1'b0;
        sample();
        drain(5);

        // Randomized traffic with occasional resets.
        for (int cyc = 0; cyc < 800; cyc++) begin
            sample();
            a0 = req0_ready;
            a1 = req1_ready;
            tick();
            rst = ($urandom_range(0, 199) == 0);
            res_ready = ($urandom_range(0, 9) < 7);
            if (a0) begin
                req0_valid = 1'($urandom);
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 1'($urandom);
            end else if (req0_valid) begin
                if ($urandom_range(0, 15) == 0) req0_valid = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                req0_valid = 1'b1;
                req0_a = 8'($urandom); req0_b = 8'($urandom); req0_mode = 1'($urandom);
            end
            if (a1) begin
                req1_valid = 1'($urandom);
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 1'($urandom);
            end else if (req1_valid) begin
                if ($urandom_range(0, 15) == 0) req1_valid = 1'b0;
            end else if ($urandom_range(0, 1) == 1) begin
                req1_valid = 1'b1;
                req1_a = 8'($urandom); req1_b = 8'($urandom); req1_mode = 1'($urandom);
            end
        end
        tick();
        rst = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready = 1'b1;
        sample();
        drain(5);
        chk("random_handshakes_seen", (hs_total > 20), 1);

`ifdef BITOP_STATS_EN
        // Counter: three ops after reset, then saturation from a forced near-limit value.
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sample();
        single_op(0, 8'h01, 8'h02, 1'b0, d, s);
        single_op(1, 8'h0F, 8'hFF, 1'b1, d, s);
        single_op(0, 8'hAA, 8'hAA, 1'b0, d, s);
        chk("stats_three_ops", op_count, 3);
        tick();
        force dut.r_op_count = 16'hFFFE;
        m_count = 16'hFFFE;
        sample();
        tick();
        release dut.r_op_count;
        sample();
        single_op(0, 8'h11, 8'h22, 1'b0, d, s);
        single_op(1, 8'h33, 8'h44, 1'b1, d, s);
        drain(2);
        chk("stats_saturated", op_count, 16'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
